// File: rtl/uart_hex_tx.sv
// 8N1 UART transmitter that sends a 32-bit word as 8 uppercase ASCII hex characters,
// MSB nibble first, optionally followed by CR LF.
module uart_hex_tx #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  output logic        busy,
  output logic        done,
  output logic        txd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [3:0]    LAST_CHAR = SEND_CRLF ? 4'd9 : 4'd7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [3:0]    char_q, char_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic          txd_d, busy_d, done_d;
  logic          baud_end;
  logic [7:0]    char_byte;

  // Character code for index idx; digits come from the top nibble of the shift register.
  function automatic logic [7:0] char_code(input logic [3:0] idx, input logic [3:0] nib);
    if (idx == 4'd8) return 8'h0D;
    if (idx == 4'd9) return 8'h0A;
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      char_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      char_q  <= char_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      txd     <= txd_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    char_d  = char_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        shift_d = word;
        char_d  = '0;
        bit_d   = '0;
        baud_d  = '0;
      end
      START: if (baud_end) begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = DATA;
      end else baud_d = baud_q + 1'b1;
      DATA: if (baud_end) begin
        baud_d = '0;
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          state_d = STOP;
        end else bit_d = bit_q + 3'd1;
      end else baud_d = baud_q + 1'b1;
      STOP: if (baud_end) begin
        baud_d = '0;
        if (char_q == LAST_CHAR) begin
          char_d  = '0;
          state_d = IDLE;
        end else begin
          // Next character: stop bit runs straight into the next start bit.
          char_d  = char_q + 4'd1;
          shift_d = shift_q << 4;
          state_d = START;
        end
      end else baud_d = baud_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they land in registers with the state.
  always_comb begin
    char_byte = char_code(char_d, shift_d[31:28]);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = char_byte[bit_d];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && baud_end && (char_q == LAST_CHAR);
  end

endmodule
